// File: rtl/x_tdc_decoder.sv
// Thermometer-code TDC decoder: scans a 256-bit delay-line snapshot 16 bits per cycle for the
// first transition and counts its ones. Optional majority bubble filter: X_TDC_DECODER_BUBBLE_FILTER_EN.
module x_tdc_decoder (
  input  logic         i_clk,
  input  logic         i_nrst,
  input  logic         i_start,
  input  logic [255:0] i_data,
  input  logic         i_ready,
  output logic         o_busy,
  output logic         o_valid,
  output logic         o_found,
  output logic         o_pol,
  output logic [7:0]   o_pos,
  output logic [8:0]   o_ones
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]   state_q;
  logic [3:0]   cnt_q;
  logic         prev_q;
  logic [255:0] raw_q;
  logic [255:0] srch;
  logic [255:0] snap_srch;
  logic         valid_q;
  logic         found_q;
  logic         pol_q;
  logic [7:0]   pos_q;
  logic [8:0]   ones_q;

`ifdef X_TDC_DECODER_BUBBLE_FILTER_EN
  logic [255:0] filt_q;
  logic [257:0] ext;

  // Replicate the end taps so the majority window is defined at both ends.
  always_comb begin
    ext = {i_data[255], i_data, i_data[0]};
    snap_srch = '0;
    for (int i = 0; i < 256; i++) begin
      snap_srch[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      filt_q <= '0;
    end else if (state_q == StIdle && i_start) begin
      filt_q <= snap_srch;
    end
  end

  assign srch = filt_q;
`else
  assign snap_srch = i_data;
  assign srch      = raw_q;
`endif

  logic [15:0] cnt_chunk;
  logic [15:0] srch_chunk;
  logic [4:0]  pc;
  logic        hit;
  logic [7:0]  hit_pos;
  logic        bprev;

  always_comb begin
    cnt_chunk  = raw_q[{cnt_q, 4'd0} +: 16];
    srch_chunk = srch[{cnt_q, 4'd0} +: 16];
    pc      = '0;
    hit     = 1'b0;
    hit_pos = '0;
    bprev   = prev_q;
    for (int j = 0; j < 16; j++) begin
      pc = pc + {4'd0, cnt_chunk[j]};
      // Bit 0 has no left neighbour; every other bit compares to the one below it.
      if (!hit && (cnt_q != 4'd0 || j != 0) && srch_chunk[j] != bprev) begin
        hit     = 1'b1;
        hit_pos = {cnt_q, 4'(j)};
      end
      bprev = srch_chunk[j];
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      raw_q   <= '0;
      valid_q <= 1'b0;
      found_q <= 1'b0;
      pol_q   <= 1'b0;
      pos_q   <= '0;
      ones_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            raw_q   <= i_data;
            pol_q   <= snap_srch[0];
            found_q <= 1'b0;
            pos_q   <= '0;
            ones_q  <= '0;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            state_q <= StScan;
          end
        end
        StScan: begin
          ones_q <= ones_q + {4'd0, pc};
          if (!found_q && hit) begin
            found_q <= 1'b1;
            pos_q   <= hit_pos;
          end
          prev_q <= srch_chunk[15];
          cnt_q  <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          // One settling cycle in DONE before valid rises.
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (i_ready) begin
            valid_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_busy  = (state_q != StIdle);
  assign o_valid = valid_q;
  assign o_found = found_q;
  assign o_pol   = pol_q;
  assign o_pos   = pos_q;
  assign o_ones  = ones_q;

endmodule

// File: tb/tb_x_tdc_decoder.sv
// Directed self-checking bench for x_tdc_decoder; expectations follow the build's
// X_TDC_DECODER_BUBBLE_FILTER_EN setting.
module tb_x_tdc_decoder;

  logic         i_clk = 1'b0;
  logic         i_nrst;
  logic         i_start;
  logic [255:0] i_data;
  logic         i_ready;
  logic         o_busy;
  logic         o_valid;
  logic         o_found;
  logic         o_pol;
  logic [7:0]   o_pos;
  logic [8:0]   o_ones;

  int n_vec  = 0;
  int n_fail = 0;

  x_tdc_decoder dut (
    .i_clk   (i_clk),
    .i_nrst  (i_nrst),
    .i_start (i_start),
    .i_data  (i_data),
    .i_ready (i_ready),
    .o_busy  (o_busy),
    .o_valid (o_valid),
    .o_found (o_found),
    .o_pol   (o_pol),
    .o_pos   (o_pos),
    .o_ones  (o_ones)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Accept one snapshot, scramble i_data afterwards, and return the edges until o_valid.
  task automatic start_op(input logic [255:0] d, output int lat);
    @(negedge i_clk);
    i_data  = d;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_data  = {8{$urandom}};
    lat = 0;
    while (!o_valid && lat < 40) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_vec(input string tag, input logic [255:0] d, input logic found,
                         input logic pol, input logic [7:0] pos, input logic [8:0] ones);
    int lat;
    start_op(d, lat);
    check({tag, " latency"}, lat, 17);
    check({tag, " busy"}, o_busy, 1);
    check({tag, " found"}, o_found, found);
    check({tag, " pol"}, o_pol, pol);
    check({tag, " pos"}, o_pos, pos);
    check({tag, " ones"}, o_ones, ones);
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
    check({tag, " idle busy"}, o_busy, 0);
    check({tag, " idle valid"}, o_valid, 0);
    check({tag, " held pos"}, o_pos, pos);
    check({tag, " held ones"}, o_ones, ones);
  endtask

  initial begin
    logic [255:0] v;
    int lat;
    int valid_seen;
    i_nrst  = 1'b0;
    i_start = 1'b0;
    i_data  = '0;
    i_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst busy", o_busy, 0);
    check("rst valid", o_valid, 0);
    check("rst pos", o_pos, 0);
    check("rst ones", o_ones, 0);
    i_nrst = 1'b1;
    @(posedge i_clk);

    v = 256'hFFFF;
    run_vec("low16", v, 1'b1, 1'b1, 8'd16, 9'd16);
    v = ~256'd0 << 32;
    run_vec("seam32", v, 1'b1, 1'b0, 8'd32, 9'd224);
    v = ~256'd0;
    run_vec("ones", v, 1'b0, 1'b1, 8'd0, 9'd256);
    v = '0;
    run_vec("zeros", v, 1'b0, 1'b0, 8'd0, 9'd0);
    v = '0;
    v[255] = 1'b1;
    run_vec("top", v, 1'b1, 1'b0, 8'd255, 9'd1);
    v = 256'd1;
    run_vec("bit0", v, 1'b1, 1'b1, 8'd1, 9'd1);
    v = (256'd1 << 100) - 256'd1;
    v[50] = 1'b0;
`ifdef X_TDC_DECODER_BUBBLE_FILTER_EN
    run_vec("bubble", v, 1'b1, 1'b1, 8'd100, 9'd99);
`else
    run_vec("bubble", v, 1'b1, 1'b1, 8'd50, 9'd99);
`endif

    // Back-pressure with an ignored start inside DONE and on the handshake edge.
    v = 256'h00FF_FFFF;
    start_op(v, lat);
    check("bp latency", lat, 17);
    for (int i = 0; i < 5; i++) begin
      i_start = (i == 2);
      @(posedge i_clk);
      #1;
      check("bp valid", o_valid, 1);
      check("bp pos", o_pos, 24);
      check("bp ones", o_ones, 24);
    end
    i_start = 1'b1;
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_ready = 1'b0;
    check("bp busy after", o_busy, 0);
    check("bp valid after", o_valid, 0);
    @(posedge i_clk);
    #1;
    check("bp no requeue", o_busy, 0);

    // Reset mid-scan at chunk 7.
    @(negedge i_clk);
    i_data  = ~256'd0 << 8;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (7) @(posedge i_clk);
    #1;
    i_nrst = 1'b0;
    #1;
    check("mid rst busy", o_busy, 0);
    check("mid rst valid", o_valid, 0);
    check("mid rst found", o_found, 0);
    check("mid rst pol", o_pol, 0);
    check("mid rst pos", o_pos, 0);
    check("mid rst ones", o_ones, 0);
    @(negedge i_clk);
    i_nrst = 1'b1;
    i_ready = 1'b1;
    valid_seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge i_clk);
      #1;
      if (o_valid || o_busy) valid_seen++;
    end
    i_ready = 1'b0;
    check("post rst quiet", valid_seen, 0);
    check("post rst ones", o_ones, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/x_tdc_decoder.md
X_TDC_DECODER -- requirements
Module: x_tdc_decoder

Interface
REQ-001 SHALL have port i_clk  input  1  system clock (12 MHz domain); all logic is rising-edge.
REQ-002 SHALL have port i_nrst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port i_start  input  1  request to decode i_data; sampled only in IDLE.
REQ-004 SHALL have port i_data  input  256  delay-line snapshot; bit 0 is the tap nearest the line input.
REQ-005 SHALL have port i_ready  input  1  consumer accepts the result when high with o_valid.
REQ-006 SHALL have port o_busy  output  1  high in SCAN and DONE; i_start is ignored while high.
REQ-007 SHALL have port o_valid  output  1  result valid; held until accepted.
REQ-008 SHALL have port o_found  output  1  at least one transition exists in the snapshot.
REQ-009 SHALL have port o_pol  output  1  value of snapshot bit 0; gives the edge direction.
REQ-010 SHALL have port o_pos  output  8  index n of the first transition.
REQ-011 SHALL have port o_ones  output  9  count of ones in the raw snapshot, 0..256.

Function
REQ-012 SHALL implement FSM states IDLE, SCAN and DONE.
REQ-013 IDLE with i_start=1 SHALL latch i_data into an internal 256-bit register, clear the accumulators, reset the chunk counter to 0, and go to SCAN on the next edge.
REQ-014 SCAN SHALL process one 16-bit chunk per cycle (chunk k = bits 16k..16k+15, k = 0..15), using a 4-bit chunk counter.
REQ-015 Transition definition: the first index n, 1..255, with bit[n] != bit[n-1], searched in ascending order.
REQ-016 Chunk seam: the boundary compare between bit 16k-1 and bit 16k SHALL use the last bit of the previous chunk, carried in a register.
REQ-017 Once a transition is found, o_pos SHALL NOT be overwritten by later chunks.
REQ-018 o_ones SHALL accumulate the chunk popcount every SCAN cycle, at 9-bit width, with no saturation; 256 ones gives 9'd256.
REQ-019 When the chunk counter reaches 15 and that chunk is processed, the FSM SHALL enter DONE.
REQ-020 o_valid SHALL assert exactly 17 cycles after the i_start accept edge.
REQ-021 DONE SHALL hold o_valid=1 with stable outputs until o_valid and i_ready are both high; it then returns to IDLE on that edge.
REQ-022 No-transition case (all-0 or all-1 snapshot) SHALL give o_found=0 and o_pos=0.
REQ-023 i_start asserted in SCAN or DONE SHALL be ignored, not queued; this includes the cycle of the DONE handshake.
REQ-024 i_data changes after the accept edge SHALL NOT affect the result.
REQ-025 o_busy SHALL equal (state != IDLE).
REQ-026 o_found, o_pol, o_pos and o_ones SHALL keep their last values in IDLE until the next accept.

Reset
REQ-027 Asserting i_nrst low SHALL force IDLE and clear all outputs and internal registers to 0, at any time including mid-SCAN or in DONE.
REQ-028 An operation interrupted by reset SHALL NOT produce o_valid after reset is released.

Configuration
REQ-029 Macro X_TDC_DECODER_BUBBLE_FILTER_EN defined: the snapshot SHALL be majority-filtered at accept, f[i] = maj(d[i-1], d[i], d[i+1]), with d[-1]=d[0] and d[256]=d[255].
REQ-030 With the filter enabled, edge search and o_pol SHALL use the filtered copy; o_ones SHALL still count raw bits; latency SHALL be unchanged.
REQ-031 Macro undefined: no filter logic; edge search SHALL use the raw snapshot.

Verification
REQ-032 Snapshot 256'h0...0FFFF (bits 0..15 = 1), i_ready=1 -> o_valid at cycle 17 after accept; o_found=1, o_pol=1, o_pos=16, o_ones=16.
REQ-033 Seam check: only bits 32..255 = 1 -> o_pos=32, o_pol=0, o_ones=224.
REQ-034 All ones -> o_found=0, o_pos=0, o_pol=1, o_ones=256; all zeros -> o_found=0, o_ones=0.
REQ-035 Hold i_ready=0 for 5 cycles after o_valid, pulse i_start mid-DONE, then raise i_ready -> outputs stable throughout, one accept only, o_busy=0 on the next cycle.
REQ-036 Assert i_nrst low at SCAN chunk 7, then release -> IDLE, all outputs 0, no o_valid.
REQ-037 Filter defined: bits 0..99 = 1 except bit 50 = 0 -> o_pos=100, o_ones=99; filter undefined: same stimulus -> o_pos=50.
